rom_bus_arbiter: RTL and testbench
==================================

ROM_BUS_ARBITER -- requirements
Module: rom_bus_arbiter

Interface
REQ-001 SHALL have parameter ROM_BYTES, default 9216, memory size in bytes; used for the range check.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width of every address port.
REQ-003 m_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 p_reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-port read request; held with if_addr until if_ack.
REQ-006 if_addr  input  ADDR_W  instruction fetch byte address.
REQ-007 if_ack, if_err  output  1 each  one-cycle completion pulse; error flag valid with ack.
REQ-008 if_rdata  output  32  fetched word, little-endian; valid while if_ack=1.
REQ-009 d_req, d_we  input  1 each  data-port request and write enable; held with d_addr, d_wdata, d_wstrb until d_ack.
REQ-010 d_addr  input  ADDR_W  data byte address; d_wdata  input  32; d_wstrb  input  4, byte enables, bit i = byte i.
REQ-011 d_ack, d_err  output  1 each; d_rdata  output  32; same semantics as the instruction port.
REQ-012 mem_addr  output  ADDR_W; mem_load, mem_store  output  1 each; mem_wdata  output  8; mem_rdata  input  32, combinational read of bytes mem_addr..mem_addr+3.

Function
REQ-013 FSM states SHALL be IDLE, READ, WRITE, DONE, with encodings from the package.
REQ-014 In IDLE, the block SHALL sample the requests and grant one port, or stay in IDLE when no request is present.
- Single request: that port is granted.
- Both requesting: the port not granted last time is granted (round-robin).
- The last-grant pointer resets to "instruction".
REQ-015 Range check: if granted addr+3 >= ROM_BYTES (computed ADDR_W+1 bits wide, no wrap), the FSM SHALL go straight to DONE with err=1 and rdata=0; mem_load and mem_store stay 0.
REQ-016 Read grant (if port, or d port with d_we=0) SHALL go IDLE->READ. READ drives mem_addr=addr and mem_load=1 for exactly one cycle, registers mem_rdata, then goes to DONE.
REQ-017 Write grant (d_we=1) SHALL go IDLE->WRITE. WRITE holds a 2-bit byte counter k=0..3 for exactly 4 cycles:
- mem_addr=d_addr+k.
- mem_wdata=d_wdata[8k+7:8k].
- mem_store=d_wstrb[k].
After k=3 the FSM goes to DONE.
REQ-018 DONE SHALL last exactly one cycle: it pulses ack (and err) on the granted port only, then returns to IDLE. rdata is held until the next ack of that port.
REQ-019 Latency from req sampled in IDLE at cycle N SHALL be:
- read: ack at N+2;
- write: ack at N+5;
- range error: ack at N+1.
REQ-020 Request timing rules:
- A request asserted during a busy transaction SHALL wait; it is never dropped.
- A requester may reassert in the cycle after its ack; that request is sampled in IDLE.
REQ-021 Write with d_wstrb=0 SHALL still take 4 cycles with no store and ack with err=0.
REQ-022 mem_load and mem_store SHALL never be 1 in the same cycle; both SHALL be 0 outside READ/WRITE.

Reset
REQ-023 p_reset low SHALL asynchronously force:
- state=IDLE, k=0, last-grant=instruction;
- all ack/err/rdata outputs, mem_load, mem_store, mem_addr and mem_wdata to 0.
REQ-024 Reset during WRITE SHALL abort the transaction with no ack; bytes already stored remain stored.

Structure
REQ-025 Package rom_arb_pkg SHALL hold the state enumeration, port-ID constants (PORT_IF=0, PORT_D=1) and the default ROM_BYTES.
REQ-026 Two-way round-robin selection SHALL live in sub-module rr_arbiter2 (inputs: two requests and last-grant; output: grant index and valid); all remaining logic stays in rom_bus_arbiter.

Verification
REQ-027 Bench SHALL cover these directed scenarios:
- Scenario 1: if_req, if_addr=0x10, memory bytes 0x10..0x13 = 13,12,11,10 (hex) -> if_ack at N+2, if_rdata=0x10111213, if_err=0.
- Scenario 2: d_req, d_we=1, d_addr=0x100, d_wdata=0xAABBCCDD, d_wstrb=4'b0101 -> stores 0xDD@0x100 and 0xBB@0x102 only, d_ack at N+5; a subsequent read of 0x100 returns 0x??BB??DD with unwritten bytes unchanged.
- Scenario 3: if_req and d_req asserted together from reset, held continuously -> grant order d, if, d, if, with no cycle in which both acks are 1.
- Scenario 4: d_req read at d_addr=9213 with ROM_BYTES=9216 -> d_ack at N+1, d_err=1, d_rdata=0, mem_load never asserted.
- Scenario 5: p_reset low during WRITE at k=2 -> outputs 0 immediately, no d_ack; after release, a new if_req completes normally in 2 cycles.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM bus arbiter: FSM state encoding,
// port identifiers and the default memory size.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int unsigned ROM_BYTES_DEFAULT = 9216;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone requester wins outright; when both
// request, the port that did not win last time is chosen.
module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  logic last,
  output logic gnt,
  output logic valid
);

  // Pick a winner from the current requests and the previous grant.
  always_comb begin
    valid = req_if | req_d;
    gnt   = PORT_IF;
    if (req_if && req_d) begin
      gnt = ~last;
    end else if (req_d) begin
      gnt = PORT_D;
    end
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one byte-addressed memory between an instruction-fetch port and a
// data port. Reads take one memory cycle (32-bit combinational read), writes
// are serialised into four byte cycles with per-byte strobes, and accesses
// that would run past the end of the memory complete at once with an error.
module rom_bus_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_BYTES = ROM_BYTES_DEFAULT,
  parameter int          ADDR_W    = 32
) (
  input  logic              m_clock,
  input  logic              p_reset,
  // instruction port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_load,
  output logic              mem_store,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Range limit widened by one bit so addr+3 can never wrap.
  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W+1)'(ROM_BYTES);

  state_t            state_reg, state_next;
  logic              gnt_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [1:0]        k_reg;
  logic              err_reg;
  logic [31:0]       if_rdata_reg;
  logic [31:0]       d_rdata_reg;

  logic              arb_gnt;
  logic              arb_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              range_err;

  rr_arbiter2 u_rr (
    .req_if (if_req),
    .req_d  (d_req),
    .last   (last_reg),
    .gnt    (arb_gnt),
    .valid  (arb_valid)
  );

  // Request attributes of whichever port the arbiter picks this cycle.
  always_comb begin
    sel_addr  = (arb_gnt == PORT_D) ? d_addr : if_addr;
    sel_we    = (arb_gnt == PORT_D) && d_we;
    range_err = ({1'b0, sel_addr} + (ADDR_W+1)'(3)) >= ROM_LIMIT;
  end

  // FSM state register.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: out-of-range grants skip straight to the ack cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          if (range_err)   state_next = DONE;
          else if (sel_we) state_next = WRITE;
          else             state_next = READ;
        end
      end
      READ:    state_next = DONE;
      WRITE:   if (k_reg == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction capture, byte counter and per-port read data holding.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      gnt_reg      <= PORT_IF;
      last_reg     <= PORT_IF;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      k_reg        <= '0;
      err_reg      <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            gnt_reg   <= arb_gnt;
            last_reg  <= arb_gnt;
            addr_reg  <= sel_addr;
            wdata_reg <= d_wdata;
            wstrb_reg <= d_wstrb;
            k_reg     <= '0;
            err_reg   <= range_err;
            if (range_err) begin
              if (arb_gnt == PORT_IF) if_rdata_reg <= '0;
              else                    d_rdata_reg  <= '0;
            end
          end
        end
        READ: begin
          if (gnt_reg == PORT_IF) if_rdata_reg <= mem_rdata;
          else                    d_rdata_reg  <= mem_rdata;
        end
        WRITE: begin
          k_reg <= k_reg + 2'd1;
          // A write carries no read data; present zero with its ack.
          if (k_reg == 2'd3) d_rdata_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes are decoded from the state so they are zero everywhere else.
  always_comb begin
    mem_addr  = '0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_wdata = '0;
    case (state_reg)
      READ: begin
        mem_addr = addr_reg;
        mem_load = 1'b1;
      end
      WRITE: begin
        mem_addr  = addr_reg + ADDR_W'(k_reg);
        mem_store = wstrb_reg[k_reg];
        mem_wdata = wdata_reg[{k_reg, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Completion pulses go only to the port that owns the transaction.
  always_comb begin
    if_ack   = (state_reg == DONE) && (gnt_reg == PORT_IF);
    d_ack    = (state_reg == DONE) && (gnt_reg == PORT_D);
    if_err   = if_ack & err_reg;
    d_err    = d_ack & err_reg;
    if_rdata = if_rdata_reg;
    d_rdata  = d_rdata_reg;
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: a byte memory model on the bus,
// a reference copy of memory owned by the bench, a table of single
// transactions, and directed sequences for arbitration and reset corners.
module tb_rom_bus_arbiter;

  localparam int ROM = 9216;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_load, mem_store;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata;

  rom_bus_arbiter #(.ROM_BYTES(ROM), .ADDR_W(32)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_err   (if_err),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_ack    (d_ack),
    .d_err    (d_err),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_load (mem_load),
    .mem_store(mem_store),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 m_clock = ~m_clock;

  // ---------------- memory on the bus and bench reference copy ----------
  logic [7:0] mem     [0:ROM-1];
  logic [7:0] ref_mem [0:ROM-1];
  logic       preload;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16: return 8'h13;
      17: return 8'h12;
      18: return 8'h11;
      19: return 8'h10;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  always @(posedge m_clock) begin
    if (preload) begin
      for (int i = 0; i < ROM; i++) mem[i] <= init_byte(i);
    end else if (mem_store && mem_addr < 32'(ROM)) begin
      mem[int'(mem_addr)] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr < 32'(ROM - 3))
      mem_rdata = {mem[int'(mem_addr) + 3], mem[int'(mem_addr) + 2],
                   mem[int'(mem_addr) + 1], mem[int'(mem_addr)]};
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]};
  endfunction

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int mutex_bad = 0;

  always @(negedge m_clock) begin
    if (mem_load && mem_store) mutex_bad++;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    bit          chk_rd;
    int          loads;
    int          stores;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  // One complete transaction, started at a falling edge while the DUT idles.
  task automatic do_txn(input string tag, input bit is_d, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit exp_err, input int exp_lat);
    exp_t e;
    exp_t p;
    int   cyc;
    int   loads;
    int   stores;
    int   other;
    bit   got_ack;
    bit   is_wr;
    is_wr    = is_d && we;
    e.port   = is_d;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.chk_rd = !is_wr;
    e.rdata  = (exp_err || is_wr) ? 32'h0 : model_read(addr);
    e.loads  = (exp_err || is_wr) ? 0 : 1;
    e.stores = (exp_err || !is_wr) ? 0 : $countones(wstrb);
    sb_q.push_back(e);
    if (is_wr && !exp_err)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[int'(addr) + b] = wdata[8*b +: 8];

    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end

    cyc = 0; loads = 0; stores = 0; other = 0; got_ack = 1'b0;
    while (!got_ack && cyc < 20) begin
      @(posedge m_clock);
      cyc++;
      @(negedge m_clock);
      loads  += int'(mem_load);
      stores += int'(mem_store);
      if (is_d ? if_ack : d_ack) other++;
      got_ack = is_d ? d_ack : if_ack;
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    if (!got_ack) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ack after %0d cycles, required ack", tag, cyc);
      void'(sb_q.pop_front());
    end else begin
      p = sb_q.pop_front();
      check({tag, " latency"}, 128'(cyc), 128'(p.lat));
      check({tag, " err"}, 128'(is_d ? d_err : if_err), 128'(p.err));
      if (p.chk_rd) check({tag, " rdata"}, 128'(is_d ? d_rdata : if_rdata), 128'(p.rdata));
      check({tag, " load cycles"}, 128'(loads), 128'(p.loads));
      check({tag, " store cycles"}, 128'(stores), 128'(p.stores));
      check({tag, " other port ack"}, 128'(other), 128'(0));
    end
    @(posedge m_clock);
    @(negedge m_clock);
    check({tag, " ack is one cycle"}, 128'({if_ack, d_ack}), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t p;
    int   cyc;
    int   acks;
    int   both;
    int   stray;

    // Table: {is_d, we, addr, wdata, wstrb, exp_err, exp_lat}
    vecs[0]  = '{1'b1, 1'b0, 32'h100,      32'h0,        4'h0, 1'b0, 2};
    vecs[1]  = '{1'b0, 1'b0, 32'h100,      32'h0,        4'h0, 1'b0, 2};
    vecs[2]  = '{1'b1, 1'b0, 32'd9213,     32'h0,        4'h0, 1'b1, 1};
    vecs[3]  = '{1'b0, 1'b0, 32'd9212,     32'h0,        4'h0, 1'b0, 2};
    vecs[4]  = '{1'b0, 1'b0, 32'd9213,     32'h0,        4'h0, 1'b1, 1};
    vecs[5]  = '{1'b1, 1'b1, 32'd9213,     32'h55667788, 4'hF, 1'b1, 1};
    vecs[6]  = '{1'b1, 1'b1, 32'h40,       32'hDEADBEEF, 4'h0, 1'b0, 5};
    vecs[7]  = '{1'b1, 1'b0, 32'h40,       32'h0,        4'h0, 1'b0, 2};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        4'h0, 1'b1, 1};
    vecs[9]  = '{1'b1, 1'b1, 32'h41,       32'h01020304, 4'hF, 1'b0, 5};
    vecs[10] = '{1'b0, 1'b0, 32'h40,       32'h0,        4'h0, 1'b0, 2};
    vecs[11] = '{1'b1, 1'b0, 32'h44,       32'h0,        4'h0, 1'b0, 2};

    for (int i = 0; i < ROM; i++) ref_mem[i] = init_byte(i);

    p_reset = 1'b0; preload = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    @(posedge m_clock);
    @(negedge m_clock);
    preload = 1'b0;
    check("reset outputs",
          128'({if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
                mem_addr, mem_load, mem_store, mem_wdata}), 128'(0));
    p_reset = 1'b1;
    @(negedge m_clock);

    // Scenario 1: instruction fetch of a known little-endian word.
    do_txn("s1 if read 0x10", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 2);
    check("s1 if_rdata value", 128'(if_rdata), 128'(32'h10111213));

    // Scenario 2: strobed write, then read back through the data port.
    do_txn("s2 d write 0x100", 1'b1, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, 1'b0, 5);
    do_txn("s2 d readback", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 2);
    check("s2 readback value", 128'(d_rdata),
          128'({init_byte(32'h103), 8'hBB, init_byte(32'h101), 8'hDD}));

    // Table of single transactions (includes the out-of-range read of scenario 4).
    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Scenario 5: reset arrives while the write is on byte 2.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h11223344; d_wstrb = 4'hF;
    repeat (3) begin
      @(posedge m_clock);
      @(negedge m_clock);
    end
    check("s5 write at k=2", 128'({mem_store, mem_addr, mem_wdata}),
          128'({1'b1, 32'h202, 8'h22}));
    p_reset = 1'b0;
    #1;
    check("s5 async reset outputs",
          128'({if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
                mem_addr, mem_load, mem_store, mem_wdata}), 128'(0));
    d_req = 1'b0; d_we = 1'b0;
    ref_mem[32'h200] = 8'h44;
    ref_mem[32'h201] = 8'h33;
    stray = 0;
    repeat (2) begin
      @(posedge m_clock);
      @(negedge m_clock);
      stray += int'(d_ack);
    end
    p_reset = 1'b1;
    repeat (3) begin
      @(posedge m_clock);
      @(negedge m_clock);
      stray += int'(d_ack);
    end
    check("s5 no d_ack after abort", 128'(stray), 128'(0));
    do_txn("s5 if read 0x200", 1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 2);

    // Scenario 3: both ports request from reset and hold their requests.
    p_reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    sb_q.delete();
    for (int n = 0; n < 4; n++) begin
      p.port   = (n % 2 == 0);
      p.rdata  = p.port ? model_read(32'h100) : model_read(32'h10);
      p.err    = 1'b0; p.lat = 0; p.chk_rd = 1'b1; p.loads = 1; p.stores = 0;
      sb_q.push_back(p);
    end
    @(negedge m_clock);
    p_reset = 1'b1;
    acks = 0; both = 0; cyc = 0;
    while (acks < 4 && cyc < 40) begin
      @(posedge m_clock);
      cyc++;
      @(negedge m_clock);
      if (if_ack && d_ack) both++;
      if (if_ack || d_ack) begin
        p = sb_q.pop_front();
        check($sformatf("s3 grant %0d port", acks), 128'(d_ack), 128'(p.port));
        check($sformatf("s3 grant %0d rdata", acks),
              128'(d_ack ? d_rdata : if_rdata), 128'(p.rdata));
        acks++;
        if (acks == 4) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("s3 ack count", 128'(acks), 128'(4));
    check("s3 simultaneous acks", 128'(both), 128'(0));
    @(posedge m_clock);
    @(negedge m_clock);

    check("load/store never together", 128'(mutex_bad), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
